// File: rtl/text_console_ctrl.sv
// Text console controller: turns a character stream into text-buffer writes with cursor tracking.
// Latency: printable char writes in the first inactive-area cycle after acceptance; controls act in the accept cycle.
// Backpressure: o_char_ready low outside IDLE; buffer writes stall while the display is reading.
module text_console_ctrl #(
   parameter int          COLS       = 32,
   parameter int          ROWS       = 16,
   parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
   input  logic       i_pix_clk,
   input  logic       i_reset,
   input  logic       i_in_active_area,
   input  logic       i_char_valid,
   input  logic [7:0] i_char,
   output logic       o_char_ready,
   output logic       o_wr_en,
   output logic [8:0] o_wr_addr,
   output logic [7:0] o_wr_data,
   output logic [3:0] o_cursor_row,
   output logic [4:0] o_cursor_col,
   output logic       o_busy
);

   localparam logic [4:0] LAST_COL = 5'(COLS - 1);
   localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
   localparam logic [8:0] LAST_ADDR = 9'h1FF;

   typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

   state_t     r_state, w_state_nxt;
   logic [3:0] r_row, w_row_nxt;
   logic [4:0] r_col, w_col_nxt;
   logic [7:0] r_char, w_char_nxt;
   logic [8:0] r_addr, w_addr_nxt;
   logic [8:0] r_clr_cnt, w_clr_cnt_nxt;
   logic       w_xfer;
   logic       w_printable;
   logic [3:0] w_adv_row;
   logic [4:0] w_adv_col;
   logic [3:0] w_lf_row;

   assign o_char_ready = (r_state == IDLE) && !i_reset;
   assign o_busy       = (r_state != IDLE) && !i_reset;
   assign w_xfer       = i_char_valid && o_char_ready;
   assign w_printable  = (i_char >= 8'h20) && (i_char <= 8'h7E);

   // Buffer writes only outside the active area; address/data come from state-selected registers so they stay stable.
   assign o_wr_en   = !i_reset && !i_in_active_area && ((r_state == WRITE) || (r_state == CLEAR));
   assign o_wr_addr = (r_state == CLEAR) ? r_clr_cnt : r_addr;
   assign o_wr_data = (r_state == CLEAR) ? CLEAR_CHAR : r_char;

   assign o_cursor_row = r_row;
   assign o_cursor_col = r_col;

   // Cursor advance after a printed character, wrapping column then row with no scrolling.
   always_comb begin
      w_lf_row  = (r_row == LAST_ROW) ? 4'd0 : r_row + 4'd1;
      w_adv_row = r_row;
      w_adv_col = r_col + 5'd1;
      if (r_col == LAST_COL) begin
         w_adv_col = 5'd0;
         w_adv_row = w_lf_row;
      end
   end

   // Next-state logic: control codes act immediately in IDLE; printable chars and form feed go through write states.
   always_comb begin
      w_state_nxt   = r_state;
      w_row_nxt     = r_row;
      w_col_nxt     = r_col;
      w_char_nxt    = r_char;
      w_addr_nxt    = r_addr;
      w_clr_cnt_nxt = r_clr_cnt;
      case (r_state)
         IDLE: begin
            if (w_xfer) begin
               if (w_printable) begin
                  w_char_nxt  = i_char;
                  w_addr_nxt  = {r_row, r_col};
                  w_state_nxt = WRITE;
               end else begin
                  case (i_char)
                     8'h0A: begin
                        w_col_nxt = 5'd0;
                        w_row_nxt = w_lf_row;
                     end
                     8'h0D: w_col_nxt = 5'd0;
                     8'h08: begin
                        if (r_col != 5'd0) begin
                           w_col_nxt = r_col - 5'd1;
                        end else if (r_row != 4'd0) begin
                           w_row_nxt = r_row - 4'd1;
                           w_col_nxt = LAST_COL;
                        end
                     end
                     8'h0C: begin
                        w_clr_cnt_nxt = 9'd0;
                        w_state_nxt   = CLEAR;
                     end
                     default: ;
                  endcase
               end
            end
         end
         WRITE: begin
            if (!i_in_active_area) begin
               w_row_nxt   = w_adv_row;
               w_col_nxt   = w_adv_col;
               w_state_nxt = IDLE;
            end
         end
         CLEAR: begin
            if (!i_in_active_area) begin
               w_clr_cnt_nxt = r_clr_cnt + 9'd1;
               if (r_clr_cnt == LAST_ADDR) begin
                  w_row_nxt   = 4'd0;
                  w_col_nxt   = 5'd0;
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, cursor and latched write registers; reset abandons any write or clear in progress.
   always_ff @(posedge i_pix_clk) begin
      if (i_reset) begin
         r_state   <= IDLE;
         r_row     <= 4'd0;
         r_col     <= 5'd0;
         r_char    <= 8'd0;
         r_addr    <= 9'd0;
         r_clr_cnt <= 9'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_row     <= w_row_nxt;
         r_col     <= w_col_nxt;
         r_char    <= w_char_nxt;
         r_addr    <= w_addr_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
      end
   end

endmodule

// File: doc/text_console_ctrl.md
TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 32, text columns per row (cursor column wraps at COLS-1).
REQ-002 SHALL have parameter ROWS, default 16, text rows (cursor row wraps at ROWS-1).
REQ-003 SHALL have parameter CLEAR_CHAR, default 8'h20, character written to every cell by a clear.
REQ-004 SHALL have i_pix_clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have i_reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have i_in_active_area  input  1  high while the display reads the text buffer; buffer writes are forbidden then.
REQ-007 SHALL have i_char_valid  input  1  a character is offered.
REQ-008 SHALL have i_char  input  8  offered character code.
REQ-009 SHALL have o_char_ready  output  1  controller accepts i_char this cycle.
REQ-010 SHALL have o_wr_en  output  1  one-cycle text buffer write strobe.
REQ-011 SHALL have o_wr_addr  output  9  write address {row[3:0], col[4:0]}.
REQ-012 SHALL have o_wr_data  output  8  write data.
REQ-013 SHALL have o_cursor_row  output  4  current cursor row.
REQ-014 SHALL have o_cursor_col  output  5  current cursor column.
REQ-015 SHALL have o_busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, WRITE and CLEAR.
REQ-017 SHALL drive o_char_ready high only in IDLE with i_reset low; transfer occurs when i_char_valid and o_char_ready are both high on a rising edge.
REQ-018 SHALL, on transfer of a printable code (8'h20..8'h7E), latch char and address {row,col} and enter WRITE.
REQ-019 SHALL, in WRITE, hold o_wr_en low while i_in_active_area is high; in the first cycle i_in_active_area is low, it SHALL pulse o_wr_en for exactly one cycle, advance the cursor and return to IDLE.
REQ-020 SHALL advance the cursor as col+1; at col==COLS-1: col=0, row+1; at row==ROWS-1 and col==COLS-1: wrap to (0,0), with no scrolling.
REQ-021 SHALL handle 8'h0A (LF) in the transfer cycle: col=0, row+1 mod ROWS; stay IDLE; no write.
REQ-022 SHALL handle 8'h0D (CR) in the transfer cycle: col=0, row unchanged; no write.
REQ-023 SHALL handle 8'h08 (BS) in the transfer cycle: col>0 -> col-1; col==0 and row>0 -> row-1, col=COLS-1; at (0,0) unchanged; cell not erased; no write.
REQ-024 SHALL, on 8'h0C (FF), enter CLEAR with a 9-bit counter at 0.
REQ-025 SHALL, in CLEAR, write CLEAR_CHAR to the address equal to the counter on every cycle i_in_active_area is low, incrementing the counter after each write, and stall without writing while i_in_active_area is high.
REQ-026 SHALL, after the write to address 511, set cursor to (0,0) and return to IDLE on the next edge; a full clear issues exactly 512 writes.
REQ-027 SHALL accept and discard all other codes (8'h00..8'h1F except those above, and 8'h7F..8'hFF) with no cursor change and no write.
REQ-028 SHALL hold o_wr_addr and o_wr_data stable while o_wr_en is high and SHALL not care about their values otherwise.
REQ-029 SHALL produce o_cursor_row/o_cursor_col as registered values updated on the same edge as the state transition.

Reset
REQ-030 SHALL, while i_reset is high on an edge, go to IDLE, set cursor to (0,0), clear the CLEAR counter and drive o_wr_en=0, o_busy=0, o_char_ready=0.
REQ-031 SHALL abandon any WRITE or CLEAR in progress on reset with no further writes; cells already written keep their values.

Verification
REQ-032 SHALL pass: reset, then i_in_active_area=0 and 'A'(8'h41) offered -> o_wr_en pulses once, addr 9'h000, data 8'h41; cursor becomes (0,1).
REQ-033 SHALL pass: 'B' offered with i_in_active_area=1 for 10 cycles, then 0 -> no write for 10 cycles, then exactly one write; o_char_ready low throughout.
REQ-034 SHALL pass: cursor at (15,31), 'C' offered -> write at 9'h1FF, cursor becomes (0,0).
REQ-035 SHALL pass: cursor (3,0) with BS -> (2,31); LF from (2,31) -> (3,0); CR at (3,5) -> (3,0); none writes.
REQ-036 SHALL pass: FF with i_in_active_area toggling every 4 cycles -> 512 writes of 8'h20, addresses 0..511 in order, none while active; cursor (0,0), o_busy falls.
REQ-037 SHALL pass: reset asserted mid-CLEAR at counter 100 -> no further o_wr_en; IDLE with cursor (0,0) on the following cycle.
